eth_mac_10g_stats: RTL and testbench

ETH_MAC_10G_STATS -- requirements
Module: eth_mac_10g_stats

---
 rtl/eth_mac_10g_stats.sv | 122 ++++++++++++
 tb/tb_eth_mac_10g_stats.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_10g_stats.sv
// Statistics block for a 10G Ethernet MAC: saturating RX/TX event and byte counters
// with a one-cycle-latency read port and optional clear-on-read.
module eth_mac_10g_stats #(
  parameter int unsigned KEEP_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned CLEAR_ON_READ = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [KEEP_WIDTH-1:0]    rx_axis_tkeep,
  input  logic                     rx_axis_tvalid,
  input  logic                     rx_axis_tlast,
  input  logic                     rx_axis_tuser,
  input  logic                     rx_error_bad_fcs,
  input  logic                     rx_bad_block,
  input  logic                     rx_block_lock,
  input  logic                     rx_high_ber,
  input  logic [KEEP_WIDTH-1:0]    tx_axis_tkeep,
  input  logic                     tx_axis_tvalid,
  input  logic                     tx_axis_tready,
  input  logic                     tx_axis_tlast,
  input  logic                     tx_error_underflow,
  input  logic                     stats_enable,
  input  logic                     rd_en,
  input  logic [3:0]               rd_addr,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_valid
);

  localparam int NumCnt = 10;
  // Wide enough for a counter plus a full 16-bit frame byte total without overflow.
  localparam int unsigned IncW = (COUNTER_WIDTH > 16) ? COUNTER_WIDTH + 1 : 17;
  localparam logic [IncW-1:0] CntMax = {{(IncW - COUNTER_WIDTH){1'b0}}, {COUNTER_WIDTH{1'b1}}};

  function automatic logic [15:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + 16'(keep[i]);
    return n;
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_q [NumCnt];
  logic [COUNTER_WIDTH-1:0] cnt_d [NumCnt];
  logic [IncW-1:0]          inc   [NumCnt];
  logic [15:0]              acc_q, acc_d, acc_sat;
  logic [16:0]              acc_sum;
  logic                     lock_q, ber_q;
  logic                     rx_eof, tx_acc;
  logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q;
  logic [IncW-1:0]          base, sum;

  always_comb begin
    rx_eof  = rx_axis_tvalid & rx_axis_tlast;
    tx_acc  = tx_axis_tvalid & tx_axis_tready;
    acc_sum = {1'b0, acc_q} + {1'b0, popcount(rx_axis_tkeep)};
    acc_sat = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    acc_d   = acc_q;
    // The accumulator runs regardless of stats_enable; only the counter update is gated.
    if (rx_axis_tvalid) acc_d = rx_axis_tlast ? 16'h0000 : acc_sat;
  end

  always_comb begin
    for (int i = 0; i < NumCnt; i++) inc[i] = '0;
    if (stats_enable) begin
      inc[0] = IncW'(rx_eof & ~rx_axis_tuser);
      inc[1] = IncW'(rx_eof & rx_axis_tuser);
      inc[2] = IncW'(rx_error_bad_fcs);
      inc[3] = (rx_eof & ~rx_axis_tuser) ? IncW'(acc_sat) : '0;
      inc[4] = IncW'(tx_acc & tx_axis_tlast);
      inc[5] = tx_acc ? IncW'(popcount(tx_axis_tkeep)) : '0;
      inc[6] = IncW'(tx_error_underflow);
      inc[7] = IncW'(rx_bad_block);
      inc[8] = IncW'(lock_q & ~rx_block_lock);
      inc[9] = IncW'(~ber_q & rx_high_ber);
    end
  end

  always_comb begin
    base = '0;
    sum  = '0;
    for (int i = 0; i < NumCnt; i++) begin
      // A cleared counter restarts from this cycle's increment so no event is lost.
      if ((CLEAR_ON_READ != 0) && rd_en && (rd_addr == 4'(i))) base = '0;
      else base = IncW'(cnt_q[i]);
      sum      = base + inc[i];
      cnt_d[i] = (sum > CntMax) ? {COUNTER_WIDTH{1'b1}} : sum[COUNTER_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NumCnt; i++) begin
        if (rd_addr == 4'(i)) rd_data_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumCnt; i++) cnt_q[i] <= '0;
      acc_q      <= '0;
      lock_q     <= 1'b0;
      ber_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumCnt; i++) cnt_q[i] <= cnt_d[i];
      acc_q      <= acc_d;
      lock_q     <= rx_block_lock;
      ber_q      <= rx_high_ber;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_eth_mac_10g_stats.sv
// Scoreboard bench for eth_mac_10g_stats; a second 8-bit-counter instance covers saturation.
module tb_eth_mac_10g_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_axis_tkeep, tx_axis_tkeep;
  logic        rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser;
  logic        rx_error_bad_fcs, rx_bad_block, rx_block_lock, rx_high_ber;
  logic        tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_error_underflow;
  logic        stats_enable, rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [7:0]  rd_data8;
  logic        rd_valid8;

  typedef struct {
    int unsigned addr;
    logic [31:0] val;
    bit          chk8;
    logic [7:0]  val8;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  eth_mac_10g_stats #(.KEEP_WIDTH(8), .COUNTER_WIDTH(32), .CLEAR_ON_READ(1)) u_dut (
    .clk(clk), .rst(rst),
    .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .rx_error_bad_fcs(rx_error_bad_fcs), .rx_bad_block(rx_bad_block),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_error_underflow(tx_error_underflow), .stats_enable(stats_enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  eth_mac_10g_stats #(.KEEP_WIDTH(8), .COUNTER_WIDTH(8), .CLEAR_ON_READ(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .rx_error_bad_fcs(rx_error_bad_fcs), .rx_bad_block(rx_bad_block),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_error_underflow(tx_error_underflow), .stats_enable(stats_enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data8), .rd_valid(rd_valid8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic read_req(input logic [3:0] a, input logic [31:0] e,
                          input bit c8 = 1'b0, input logic [7:0] e8 = 8'h00);
    exp_t x;
    x.addr = 32'(a);
    x.val  = e;
    x.chk8 = c8;
    x.val8 = e8;
    exp_q.push_back(x);
    rd_en   = 1'b1;
    rd_addr = a;
  endtask

  task automatic read(input logic [3:0] a, input logic [31:0] e,
                      input bit c8 = 1'b0, input logic [7:0] e8 = 8'h00);
    read_req(a, e, c8, e8);
    cyc();
    rd_en = 1'b0;
  endtask

  // Drives one RX frame; optionally flips stats_enable at a given beat or issues an
  // addr0 read in the same cycle as tlast.
  task automatic rx_frame(input int nbytes, input bit user, input bit fcs = 1'b0,
                          input bit rd_last = 1'b0, input logic [31:0] rd_e = 32'd0,
                          input int en_beat = -1, input bit en_val = 1'b1);
    int n;
    int b;
    n = nbytes;
    b = 0;
    while (n > 0) begin
      if (b == en_beat) stats_enable = en_val;
      rx_axis_tvalid = 1'b1;
      if (n > 8) begin
        rx_axis_tkeep = 8'hFF;
        rx_axis_tlast = 1'b0;
        n -= 8;
      end else begin
        rx_axis_tkeep    = 8'((1 << n) - 1);
        rx_axis_tlast    = 1'b1;
        rx_axis_tuser    = user;
        rx_error_bad_fcs = fcs;
        if (rd_last) read_req(4'd0, rd_e);
        n = 0;
      end
      cyc();
      b++;
      rx_axis_tvalid   = 1'b0;
      rx_axis_tlast    = 1'b0;
      rx_axis_tuser    = 1'b0;
      rx_error_bad_fcs = 1'b0;
      rd_en            = 1'b0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end else begin
        x = exp_q.pop_front();
        check_eq($sformatf("rd_addr%0d", x.addr), rd_data, x.val);
        if (x.chk8) check_eq($sformatf("rd8_addr%0d", x.addr), 32'(rd_data8), 32'(x.val8));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [12:0] rdy_pat;
    int          beat;
    rst = 1'b1;
    rx_axis_tkeep = '0; rx_axis_tvalid = 0; rx_axis_tlast = 0; rx_axis_tuser = 0;
    rx_error_bad_fcs = 0; rx_bad_block = 0; rx_block_lock = 0; rx_high_ber = 0;
    tx_axis_tkeep = '0; tx_axis_tvalid = 0; tx_axis_tready = 0; tx_axis_tlast = 0;
    tx_error_underflow = 0; stats_enable = 1; rd_en = 0; rd_addr = '0;
    #3;
    check_eq("reset_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("reset_rd_data", rd_data, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    for (int a = 0; a < 16; a++) read(4'(a), 32'd0);

    // Three good frames, then a bad frame with an FCS error.
    rx_frame(64, 1'b0);
    rx_frame(65, 1'b0);
    rx_frame(1518, 1'b0);
    read(4'd0, 32'd3);
    rx_frame(64, 1'b1, 1'b1);
    read(4'd3, 32'd1647);
    read(4'd1, 32'd1);
    read(4'd2, 32'd1);

    // TX frame of 9 beats with 4 stalled cycles, then two underflow pulses.
    rdy_pat = 13'b1101101101101;
    beat = 0;
    for (int c = 0; c < 13; c++) begin
      tx_axis_tvalid = 1'b1;
      tx_axis_tready = rdy_pat[c];
      tx_axis_tkeep  = (beat == 8) ? 8'h0F : 8'hFF;
      tx_axis_tlast  = (beat == 8);
      cyc();
      if (rdy_pat[c]) beat++;
    end
    tx_axis_tvalid = 1'b0; tx_axis_tready = 1'b0; tx_axis_tlast = 1'b0;
    tx_error_underflow = 1'b1;
    cyc(); cyc();
    tx_error_underflow = 1'b0;
    read(4'd4, 32'd1);
    read(4'd5, 32'd68);
    read(4'd6, 32'd2);

    // Clear-on-read in the same cycle as a good-frame tlast.
    rx_frame(64, 1'b0);
    rx_frame(64, 1'b0, 1'b0, 1'b1, 32'd1);
    read(4'd0, 32'd1);

    // stats_enable low for the tail of a frame, then low for the head of the next.
    rx_frame(64, 1'b0, 1'b0, 1'b0, 32'd0, 4, 1'b0);
    stats_enable = 1'b1;
    read(4'd0, 32'd0);
    read(4'd3, 32'd128);
    stats_enable = 1'b0;
    rx_frame(64, 1'b0, 1'b0, 1'b0, 32'd0, 7, 1'b1);
    read(4'd0, 32'd1);
    read(4'd3, 32'd64);

    // Lock toggles 1->0->1->0, high BER rises and holds.
    rx_high_ber = 1'b1;
    rx_block_lock = 1'b1; cyc();
    rx_block_lock = 1'b0; cyc();
    rx_block_lock = 1'b1; cyc();
    rx_block_lock = 1'b0; cyc();
    read(4'd8, 32'd2);
    read(4'd9, 32'd1);
    rx_high_ber = 1'b0;

    // Build up state plus a partial frame, then reset asynchronously.
    rx_frame(64, 1'b0);
    read(4'd3, 32'd64);
    rx_frame(64, 1'b0);
    rx_bad_block = 1'b1; cyc(); rx_bad_block = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_axis_tvalid = 1'b1; rx_axis_tkeep = 8'hFF; cyc();
    end
    rx_axis_tvalid = 1'b0;
    cyc(); cyc();
    check_eq("rd_data_hold", rd_data, 32'd64);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_rd_data", rd_data, 32'd0);
    check_eq("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    for (int a = 0; a < 16; a++) read(4'(a), 32'd0);
    rx_frame(65, 1'b0);
    read(4'd3, 32'd65);
    read(4'd0, 32'd1);

    // Saturation: 258 bad-block pulses; the 8-bit build must stop at 255.
    rx_bad_block = 1'b1;
    repeat (258) cyc();
    rx_bad_block = 1'b0;
    read(4'd7, 32'd258, 1'b1, 8'd255);
    read(4'd7, 32'd0, 1'b1, 8'd0);

    repeat (3) cyc();
    check_eq("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
